csr_trap_sequencer: RTL and testbench

CSR_TRAP_SEQUENCER -- requirements
Module: csr_trap_sequencer

---
 rtl/csr_trap_sequencer.sv | 106 ++++++++++
 tb/tb_csr_trap_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: sequences the CSR reads/writes for trap entry and mret, then issues a fetch redirect.
module csr_trap_sequencer #(
  parameter logic [11:0] ADDR_MSTATUS = 12'h300,
  parameter logic [11:0] ADDR_MTVEC   = 12'h305,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TrapReq,
  input  logic [31:0] TrapCause,
  input  logic [31:0] TrapPC,
  input  logic        MretReq,
  output logic        Busy,
  output logic        RedirectValid,
  output logic [31:0] RedirectPC,
  output logic [11:0] CSRAddr,
  output logic [31:0] CSRWriteData,
  output logic        CSRWriteEnable,
  output logic        CSRReadEnable,
  input  logic [31:0] CSRReadData
);
  typedef enum logic [3:0] {
    IDLE, T_WR_EPC, T_WR_CAUSE, T_RD_STATUS, T_WR_STATUS, T_RD_TVEC, T_CAP_TVEC,
    M_RD_STATUS, M_WR_STATUS, M_RD_EPC, M_CAP_EPC
  } state_t;
  state_t state, state_nx;
  logic [31:0] cause_q, pc_q, base, cap_pc;
  logic cap;
  assign Busy = state != IDLE;
  assign cap = state == T_CAP_TVEC || state == M_CAP_EPC;
  assign base = {CSRReadData[31:2], 2'b00};
  assign cap_pc = state == T_CAP_TVEC && CSRReadData[1:0] == 2'b01 && cause_q[31] ? base + {cause_q[29:0], 2'b00} : base;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cause_q <= '0;
      pc_q <= '0;
      RedirectValid <= 1'b0;
      RedirectPC <= '0;
    end else begin
      state <= state_nx;
      RedirectValid <= cap;
      if (cap) RedirectPC <= cap_pc;
      if (state == IDLE && TrapReq) begin
        cause_q <= TrapCause;
        pc_q <= {TrapPC[31:2], 2'b00};
      end
    end
  always_comb begin
    state_nx = state;
    CSRAddr = '0;
    CSRWriteData = '0;
    CSRWriteEnable = 1'b0;
    CSRReadEnable = 1'b0;
    case (state)
      IDLE:        state_nx = TrapReq ? T_WR_EPC : MretReq ? M_RD_STATUS : IDLE;
      T_WR_EPC:    state_nx = T_WR_CAUSE;
      T_WR_CAUSE:  state_nx = T_RD_STATUS;
      T_RD_STATUS: state_nx = T_WR_STATUS;
      T_WR_STATUS: state_nx = T_RD_TVEC;
      T_RD_TVEC:   state_nx = T_CAP_TVEC;
      M_RD_STATUS: state_nx = M_WR_STATUS;
      M_WR_STATUS: state_nx = M_RD_EPC;
      M_RD_EPC:    state_nx = M_CAP_EPC;
      default:     state_nx = IDLE;
    endcase
    // bus is held quiet while rst is high so an abandoned sequence never touches the CSR file
    if (!rst)
      case (state)
        T_WR_EPC: begin
          CSRAddr = ADDR_MEPC;
          CSRWriteData = pc_q;
          CSRWriteEnable = 1'b1;
        end
        T_WR_CAUSE: begin
          CSRAddr = ADDR_MCAUSE;
          CSRWriteData = cause_q;
          CSRWriteEnable = 1'b1;
        end
        T_RD_STATUS, M_RD_STATUS: begin
          CSRAddr = ADDR_MSTATUS;
          CSRReadEnable = 1'b1;
        end
        T_WR_STATUS: begin
          CSRAddr = ADDR_MSTATUS;
          CSRWriteData = {CSRReadData[31:13], 2'b11, CSRReadData[10:8], CSRReadData[3], CSRReadData[6:4], 1'b0, CSRReadData[2:0]};
          CSRWriteEnable = 1'b1;
        end
        M_WR_STATUS: begin
          CSRAddr = ADDR_MSTATUS;
          CSRWriteData = {CSRReadData[31:13], 2'b11, CSRReadData[10:8], 1'b1, CSRReadData[6:4], CSRReadData[7], CSRReadData[2:0]};
          CSRWriteEnable = 1'b1;
        end
        T_RD_TVEC: begin
          CSRAddr = ADDR_MTVEC;
          CSRReadEnable = 1'b1;
        end
        M_RD_EPC: begin
          CSRAddr = ADDR_MEPC;
          CSRReadEnable = 1'b1;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb_csr_trap_sequencer: vector table plus corner sequences against a small CSR-file model and redirect scoreboard.
module tb_csr_trap_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic trap_req = 1'b0, mret_req = 1'b0;
  logic [31:0] trap_cause = '0, trap_pc = '0;
  logic busy, redirect_valid, csr_we, csr_re;
  logic [31:0] redirect_pc, csr_wd, csr_rd;
  logic [11:0] csr_addr;
  logic ld = 1'b0;
  logic [31:0] ld_status = '0, ld_tvec = '0, ld_epc = '0;
  logic [31:0] m_status, m_tvec, m_epc, m_cause;
  int tests = 0, fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  csr_trap_sequencer dut (
    .clk(clk), .rst(rst), .TrapReq(trap_req), .TrapCause(trap_cause), .TrapPC(trap_pc),
    .MretReq(mret_req), .Busy(busy), .RedirectValid(redirect_valid), .RedirectPC(redirect_pc),
    .CSRAddr(csr_addr), .CSRWriteData(csr_wd), .CSRWriteEnable(csr_we), .CSRReadEnable(csr_re),
    .CSRReadData(csr_rd)
  );

  always @(posedge clk) begin
    if (ld) begin
      m_status <= ld_status;
      m_tvec <= ld_tvec;
      m_epc <= ld_epc;
      m_cause <= '0;
    end else if (csr_we)
      case (csr_addr)
        12'h300: m_status <= csr_wd;
        12'h305: m_tvec <= csr_wd;
        12'h341: m_epc <= csr_wd;
        12'h342: m_cause <= csr_wd;
        default: ;
      endcase
    if (csr_re)
      csr_rd <= csr_addr == 12'h300 ? m_status : csr_addr == 12'h305 ? m_tvec :
                csr_addr == 12'h341 ? m_epc : csr_addr == 12'h342 ? m_cause : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("bus_exclusive", {31'b0, csr_we & csr_re}, 32'h0);
    if (!busy) check("idle_bus_quiet", {31'b0, |{csr_we, csr_re, csr_addr, csr_wd}}, 32'h0);
  end

  typedef struct {
    logic trap, mret;
    logic [31:0] cause, pc, status, tvec, epc;
    logic [31:0] exp_pc, exp_status, exp_epc, exp_cause;
    int lat;
  } vec_t;
  vec_t vecs[8];

  task automatic load(input logic [31:0] s, input logic [31:0] t, input logic [31:0] e);
    ld_status = s;
    ld_tvec = t;
    ld_epc = e;
    ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  task automatic wait_redirect(input string name, input int lat);
    int n;
    logic [31:0] e;
    n = 0;
    while (!redirect_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check({name, "_latency"}, n, lat);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hX;
    check({name, "_redirect_pc"}, redirect_pc, e);
    check({name, "_busy_at_redirect"}, {31'b0, busy}, 32'h0);
    @(posedge clk);
    #1;
    check({name, "_valid_one_cycle"}, {31'b0, redirect_valid}, 32'h0);
    check({name, "_pc_hold"}, redirect_pc, e);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", i);
    load(v.status, v.tvec, v.epc);
    @(negedge clk);
    trap_req = v.trap;
    mret_req = v.mret;
    trap_cause = v.cause;
    trap_pc = v.pc;
    exp_q.push_back(v.exp_pc);
    @(posedge clk);
    #1;
    trap_req = 1'b0;
    mret_req = 1'b0;
    check({nm, "_busy"}, {31'b0, busy}, 32'h1);
    wait_redirect(nm, v.lat);
    check({nm, "_mstatus"}, m_status, v.exp_status);
    check({nm, "_mepc"}, m_epc, v.exp_epc);
    check({nm, "_mcause"}, m_cause, v.exp_cause);
  endtask

  initial begin
    int pulses;
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    vecs[0] = '{1'b1, 1'b0, 32'h2,         32'h1236,     32'h8,         32'h8000_0100, 32'h0,
                32'h8000_0100, 32'h1880,      32'h1234,      32'h2,         6};
    vecs[1] = '{1'b1, 1'b0, 32'h8000_0007, 32'h2000,     32'h0,         32'h8000_0101, 32'h0,
                32'h8000_011C, 32'h1800,      32'h2000,      32'h8000_0007, 6};
    vecs[2] = '{1'b0, 1'b1, 32'h0,         32'h0,        32'h1880,      32'h0,         32'h1234,
                32'h1234,      32'h1888,      32'h1234,      32'h0,         4};
    vecs[3] = '{1'b1, 1'b1, 32'hB,         32'h4003,     32'hFFFF_FFFF, 32'h1000_0002, 32'h0,
                32'h1000_0000, 32'hFFFF_FFF7, 32'h4000,      32'hB,         6};
    vecs[4] = '{1'b1, 1'b0, 32'h5,         32'h10,       32'h80,        32'h0000_0201, 32'h0,
                32'h200,       32'h1800,      32'h10,        32'h5,         6};
    vecs[5] = '{1'b1, 1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 32'h8,        32'hFFFF_FFF1, 32'h0,
                32'h30,        32'h1880,      32'hFFFF_FFFC, 32'h8000_0010, 6};
    vecs[6] = '{1'b0, 1'b1, 32'h0,         32'h0,        32'h0,         32'h0,         32'h8000_0003,
                32'h8000_0000, 32'h1880,      32'h8000_0003, 32'h0,         4};
    vecs[7] = '{1'b0, 1'b1, 32'h0,         32'h0,        32'hFFFF_E77F, 32'h0,         32'hFFFF_FFFF,
                32'hFFFF_FFFC, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'h0,         4};
    trap_req = 1'b1;
    trap_cause = 32'h1;
    trap_pc = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_valid", {31'b0, redirect_valid}, 32'h0);
    check("reset_pc", redirect_pc, 32'h0);
    trap_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    // mret held through an entire trap: ignored while busy, accepted on the edge ending the redirect
    load(32'h8, 32'h8000_0100, 32'h0);
    @(negedge clk);
    trap_req = 1'b1;
    mret_req = 1'b1;
    trap_cause = 32'h3;
    trap_pc = 32'h3000;
    exp_q.push_back(32'h8000_0100);
    @(posedge clk);
    #1 trap_req = 1'b0;
    pulses = 0;
    while (!redirect_valid && pulses < 20) begin
      @(posedge clk);
      #1 pulses++;
    end
    check("hold_trap_latency", pulses, 6);
    check("hold_trap_pc", redirect_pc, exp_q.pop_front());
    exp_q.push_back(32'h3000);
    @(posedge clk);
    #1 mret_req = 1'b0;
    check("hold_mret_accepted", {31'b0, busy}, 32'h1);
    wait_redirect("hold_mret", 4);
    check("hold_mstatus", m_status, 32'h1888);
    check("hold_mepc", m_epc, 32'h3000);
    // reset while in T_WR_STATUS abandons the sequence without the mstatus write
    load(32'h8, 32'h8000_0100, 32'h0);
    @(negedge clk);
    trap_req = 1'b1;
    trap_cause = 32'h2;
    trap_pc = 32'h1236;
    @(posedge clk);
    #1 trap_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_wr_status_we", {31'b0, csr_we}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mstatus_unwritten", m_status, 32'h8);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_pc_cleared", redirect_pc, 32'h0);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1 pulses += int'(redirect_valid) + int'(busy);
    end
    check("rst_no_activity", pulses, 0);
    // a request on the very first edge out of reset is taken
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    trap_req = 1'b1;
    trap_cause = 32'h8000_0007;
    trap_pc = 32'h2000;
    load(32'h0, 32'h8000_0101, 32'h0);
    exp_q.push_back(32'h8000_011C);
    @(posedge clk);
    #1 trap_req = 1'b0;
    check("first_edge_busy", {31'b0, busy}, 32'h1);
    wait_redirect("first_edge", 5);
    check("first_edge_mepc", m_epc, 32'h2000);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
